// File: rtl/hemaia_mem_chip_guard.sv
`default_nettype none
// ============================================================================
// Module   : hemaia_mem_chip_guard
// Purpose  : AXI4 chip-ID guard placed upstream of the memory system master
//            port. AW/AR whose chip-ID field (address bits at and above
//            CHIP_ID_LSB) equals chip_id_i pass through combinationally.
//            Others are accepted locally and answered with DECERR once all
//            forwarded traffic of that direction has drained, so AXI
//            ordering is kept. Forwarded AW/AR are capped at MAX_OUTSTANDING.
// Ports    : clk_i      - clock
//            rst_ni     - asynchronous active-low reset
//            chip_id_i  - local chip ID (quasi-static)
//            slv_req_i  - upstream request (AW/W/AR + B/R ready)
//            slv_rsp_o  - upstream response
//            mst_req_o  - request towards the memory system
//            mst_rsp_i  - response from the memory system
//            err_cnt_o  - saturating count of rejected AW/AR
// Config   : HEMAIA_MEM_GUARD_ERR_CNT_EN - when defined, err_cnt_o counts
//            rejected AW/AR; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================

package hemaia_mem_chip_guard_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  cache;
        logic [2:0]  prot;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_rsp_t;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

endpackage

module hemaia_mem_chip_guard #(
    parameter type         AXI_REQ_T       = hemaia_mem_chip_guard_pkg::axi_req_t,
    parameter type         AXI_RSP_T       = hemaia_mem_chip_guard_pkg::axi_rsp_t,
    parameter type         CHIP_ID_T       = logic [7:0],
    parameter int unsigned ADDR_WIDTH      = 48,
    parameter int unsigned CHIP_ID_LSB     = 40,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  CHIP_ID_T    chip_id_i,
    input  AXI_REQ_T    slv_req_i,
    output AXI_RSP_T    slv_rsp_o,
    output AXI_REQ_T    mst_req_o,
    input  AXI_RSP_T    mst_rsp_i,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned c_ID_W  = $bits(slv_rsp_o.b.id);
    localparam int unsigned c_LEN_W = $bits(slv_req_i.ar.len);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_LEN_W-1:0] c_LEN_ONE  = c_LEN_W'(1);
    localparam logic [1:0]         c_DECERR   = 2'b11;

    localparam logic [1:0] c_W_PASS   = 2'd0;
    localparam logic [1:0] c_W_DRAIN  = 2'd1;
    localparam logic [1:0] c_W_ABSORB = 2'd2;
    localparam logic [1:0] c_W_RESP   = 2'd3;

    localparam logic [1:0] c_R_PASS  = 2'd0;
    localparam logic [1:0] c_R_DRAIN = 2'd1;
    localparam logic [1:0] c_R_BURST = 2'd2;

    logic [1:0]         r_w_state;
    logic [1:0]         r_r_state;
    logic [c_CNT_W-1:0] r_aw_out;
    logic [c_CNT_W-1:0] r_w_out;
    logic [c_CNT_W-1:0] r_ar_out;
    logic [c_ID_W-1:0]  r_w_id;
    logic [c_ID_W-1:0]  r_r_id;
    logic [c_LEN_W-1:0] r_ar_len;
    logic [c_LEN_W-1:0] r_r_beat;

    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [ADDR_WIDTH-1:0] w_ar_addr;
    CHIP_ID_T              w_aw_chip;
    CHIP_ID_T              w_ar_chip;
    logic                  w_aw_match;
    logic                  w_ar_match;
    logic                  w_aw_room;
    logic                  w_ar_room;
    logic                  w_w_open;
    logic                  w_aw_fwd_hs;
    logic                  w_w_fwd_last;
    logic                  w_b_hs;
    logic                  w_ar_fwd_hs;
    logic                  w_r_last_hs;
    logic                  w_aw_rej;
    logic                  w_ar_rej;
    logic                  w_err_w_done;
    logic                  w_err_b_hs;
    logic                  w_err_r_hs;
    logic                  w_err_r_last;

    // Chip-ID field extraction; the shift reads the full address so the whole
    // vector participates.
    assign w_aw_addr  = slv_req_i.aw.addr;
    assign w_ar_addr  = slv_req_i.ar.addr;
    assign w_aw_chip  = CHIP_ID_T'(w_aw_addr >> CHIP_ID_LSB);
    assign w_ar_chip  = CHIP_ID_T'(w_ar_addr >> CHIP_ID_LSB);
    assign w_aw_match = (w_aw_chip == chip_id_i);
    assign w_ar_match = (w_ar_chip == chip_id_i);

    // Limits use the registered counts, so a same-cycle decrement never
    // unblocks a stalled request.
    assign w_aw_room = (r_aw_out < c_CNT_MAX);
    assign w_ar_room = (r_ar_out < c_CNT_MAX);
    assign w_w_open  = (r_w_out != c_CNT_ZERO);

    assign w_aw_fwd_hs  = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
    assign w_w_fwd_last = mst_req_o.w_valid & mst_rsp_i.w_ready & slv_req_i.w.last;
    assign w_b_hs       = mst_rsp_i.b_valid & mst_req_o.b_ready;
    assign w_ar_fwd_hs  = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
    assign w_r_last_hs  = mst_rsp_i.r_valid & mst_req_o.r_ready & mst_rsp_i.r.last;

    assign w_aw_rej     = (r_w_state == c_W_PASS) & slv_req_i.aw_valid & ~w_aw_match;
    assign w_ar_rej     = (r_r_state == c_R_PASS) & slv_req_i.ar_valid & ~w_ar_match;
    assign w_err_w_done = (r_w_state == c_W_ABSORB) & slv_req_i.w_valid & slv_req_i.w.last;
    assign w_err_b_hs   = (r_w_state == c_W_RESP) & slv_req_i.b_ready;
    assign w_err_r_hs   = (r_r_state == c_R_BURST) & slv_req_i.r_ready;
    assign w_err_r_last = (r_r_beat == r_ar_len);

    // Channel muxing: payloads always pass through, only handshakes are gated.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = 1'b0;
        mst_req_o.w_valid  = 1'b0;
        mst_req_o.ar_valid = 1'b0;
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = 1'b0;
        slv_rsp_o.w_ready  = 1'b0;
        slv_rsp_o.ar_ready = 1'b0;

        // Ready is qualified with valid so an idle channel reports not-ready.
        if (r_w_state == c_W_PASS) begin
            if (w_aw_match) begin
                if (w_aw_room) begin
                    mst_req_o.aw_valid = slv_req_i.aw_valid;
                    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & slv_req_i.aw_valid;
                end
            end else begin
                slv_rsp_o.aw_ready = slv_req_i.aw_valid;
            end
        end

        // W beats only flow once their AW has gone downstream; a rejected
        // burst is swallowed here without forwarding.
        if (r_w_state == c_W_ABSORB) begin
            slv_rsp_o.w_ready = 1'b1;
        end else if (w_w_open) begin
            mst_req_o.w_valid = slv_req_i.w_valid;
            slv_rsp_o.w_ready = mst_rsp_i.w_ready;
        end

        if (r_w_state == c_W_RESP) begin
            mst_req_o.b_ready = 1'b0;
            slv_rsp_o.b_valid = 1'b1;
            slv_rsp_o.b       = '0;
            slv_rsp_o.b.id    = r_w_id;
            slv_rsp_o.b.resp  = c_DECERR;
        end

        if (r_r_state == c_R_PASS) begin
            if (w_ar_match) begin
                if (w_ar_room) begin
                    mst_req_o.ar_valid = slv_req_i.ar_valid;
                    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & slv_req_i.ar_valid;
                end
            end else begin
                slv_rsp_o.ar_ready = slv_req_i.ar_valid;
            end
        end

        if (r_r_state == c_R_BURST) begin
            mst_req_o.r_ready = 1'b0;
            slv_rsp_o.r_valid = 1'b1;
            slv_rsp_o.r       = '0;
            slv_rsp_o.r.id    = r_r_id;
            slv_rsp_o.r.resp  = c_DECERR;
            slv_rsp_o.r.last  = w_err_r_last;
        end
    end

    function automatic logic [c_CNT_W-1:0] f_cnt_next(
        input logic [c_CNT_W-1:0] cnt,
        input logic               inc,
        input logic               dec
    );
        if (inc && !dec) begin
            return cnt + c_CNT_ONE;
        end else if (!inc && dec) begin
            return cnt - c_CNT_ONE;
        end
        return cnt;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_out <= '0;
            r_w_out  <= '0;
            r_ar_out <= '0;
        end else begin
            r_aw_out <= f_cnt_next(r_aw_out, w_aw_fwd_hs, w_b_hs);
            r_w_out  <= f_cnt_next(r_w_out, w_aw_fwd_hs, w_w_fwd_last);
            r_ar_out <= f_cnt_next(r_ar_out, w_ar_fwd_hs, w_r_last_hs);
        end
    end

    // Write side. The error burst is terminated on wlast regardless of the
    // latched AWLEN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_w_state <= c_W_PASS;
            r_w_id    <= '0;
        end else begin
            case (r_w_state)
                c_W_PASS: begin
                    if (w_aw_rej) begin
                        r_w_id    <= slv_req_i.aw.id;
                        r_w_state <= c_W_DRAIN;
                    end
                end
                c_W_DRAIN: begin
                    // All B back implies all forwarded W delivered as well.
                    if (r_aw_out == c_CNT_ZERO) begin
                        r_w_state <= c_W_ABSORB;
                    end
                end
                c_W_ABSORB: begin
                    if (w_err_w_done) begin
                        r_w_state <= c_W_RESP;
                    end
                end
                c_W_RESP: begin
                    if (w_err_b_hs) begin
                        r_w_state <= c_W_PASS;
                    end
                end
                default: r_w_state <= c_W_PASS;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r_state <= c_R_PASS;
            r_r_id    <= '0;
            r_ar_len  <= '0;
            r_r_beat  <= '0;
        end else begin
            case (r_r_state)
                c_R_PASS: begin
                    if (w_ar_rej) begin
                        r_r_id    <= slv_req_i.ar.id;
                        r_ar_len  <= slv_req_i.ar.len;
                        r_r_beat  <= '0;
                        r_r_state <= c_R_DRAIN;
                    end
                end
                c_R_DRAIN: begin
                    if (r_ar_out == c_CNT_ZERO) begin
                        r_r_state <= c_R_BURST;
                    end
                end
                c_R_BURST: begin
                    if (w_err_r_hs) begin
                        if (w_err_r_last) begin
                            r_r_state <= c_R_PASS;
                        end else begin
                            r_r_beat <= r_r_beat + c_LEN_ONE;
                        end
                    end
                end
                default: r_r_state <= c_R_PASS;
            endcase
        end
    end

`ifdef HEMAIA_MEM_GUARD_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [16:0] w_err_sum;

    // AW and AR rejects in the same cycle both count.
    assign w_err_sum = {1'b0, r_err_cnt} + {16'd0, w_aw_rej} + {16'd0, w_ar_rej};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_err_sum[16]) begin
            r_err_cnt <= 16'hFFFF;
        end else begin
            r_err_cnt <= w_err_sum[15:0];
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hemaia_mem_chip_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hemaia_mem_chip_guard
// Purpose  : Directed self-checking bench for hemaia_mem_chip_guard.
//            Drives upstream requests and downstream responses directly and
//            compares DUT outputs against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hemaia_mem_chip_guard;
    import hemaia_mem_chip_guard_pkg::*;

`ifdef HEMAIA_MEM_GUARD_ERR_CNT_EN
    localparam int c_ERR_STEP = 1;
`else
    localparam int c_ERR_STEP = 0;
`endif

    localparam logic [47:0] c_ADDR_HIT  = {8'h03, 40'h80_0000_0000};
    localparam logic [47:0] c_ADDR_MISS = {8'h05, 40'h80_0000_0000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  chip_id;
    axi_req_t    slv_req;
    axi_rsp_t    slv_rsp;
    axi_req_t    mst_req;
    axi_rsp_t    mst_rsp;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hemaia_mem_chip_guard dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .chip_id_i (chip_id),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp),
        .err_cnt_o (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slv_req = '0;
        mst_rsp = '0;
        chip_id = 8'h03;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_mst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
        chk("rst_mst_w_valid",  64'(mst_req.w_valid),  64'd0);
        chk("rst_mst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
        chk("rst_slv_b_valid",  64'(slv_rsp.b_valid),  64'd0);
        chk("rst_slv_r_valid",  64'(slv_rsp.r_valid),  64'd0);
        chk("rst_slv_aw_ready", 64'(slv_rsp.aw_ready), 64'd0);
        chk("rst_slv_w_ready",  64'(slv_rsp.w_ready),  64'd0);
        chk("rst_slv_ar_ready", 64'(slv_rsp.ar_ready), 64'd0);
        chk("rst_err_cnt",      64'(err_cnt),          64'd0);

        rst_n = 1'b1;
        mst_rsp.aw_ready = 1'b1;
        mst_rsp.w_ready  = 1'b1;
        mst_rsp.ar_ready = 1'b1;
        slv_req.b_ready  = 1'b1;
        slv_req.r_ready  = 1'b1;
        tick();

        // Pass-through write, len 3
        slv_req.aw.id   = 4'd1;
        slv_req.aw.addr = c_ADDR_HIT;
        slv_req.aw.len  = 8'd3;
        slv_req.aw_valid = 1'b1;
        #1;
        chk("pt_aw_valid", 64'(mst_req.aw_valid), 64'd1);
        chk("pt_aw_addr",  64'(mst_req.aw.addr),  64'(c_ADDR_HIT));
        chk("pt_aw_len",   64'(mst_req.aw.len),   64'd3);
        chk("pt_aw_ready", 64'(slv_rsp.aw_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slv_req.w.data  = 64'(160 + i);
            slv_req.w.strb  = 8'hFF;
            slv_req.w.last  = (i == 3);
            slv_req.w_valid = 1'b1;
            #1;
            chk("pt_w_valid", 64'(mst_req.w_valid), 64'd1);
            chk("pt_w_data",  mst_req.w.data,       64'(160 + i));
            chk("pt_w_last",  64'(mst_req.w.last),  64'(i == 3));
            chk("pt_w_ready", 64'(slv_rsp.w_ready), 64'd1);
            tick();
        end
        slv_req.w_valid = 1'b0;
        mst_rsp.b_valid = 1'b1;
        mst_rsp.b.id    = 4'd1;
        mst_rsp.b.resp  = c_RESP_OKAY;
        #1;
        chk("pt_b_valid", 64'(slv_rsp.b_valid), 64'd1);
        chk("pt_b_id",    64'(slv_rsp.b.id),    64'd1);
        chk("pt_b_resp",  64'(slv_rsp.b.resp),  64'd0);
        chk("pt_b_ready", 64'(mst_req.b_ready), 64'd1);
        tick();
        mst_rsp.b_valid = 1'b0;

        // Write reject: id 2, len 1
        slv_req.aw.id    = 4'd2;
        slv_req.aw.addr  = c_ADDR_MISS;
        slv_req.aw.len   = 8'd1;
        slv_req.aw_valid = 1'b1;
        #1;
        chk("wr_aw_ready",  64'(slv_rsp.aw_ready), 64'd1);
        chk("wr_no_mst_aw", 64'(mst_req.aw_valid), 64'd0);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w.data   = 64'hB0;
        slv_req.w.last   = 1'b0;
        slv_req.w_valid  = 1'b1;
        #1;
        chk("wr_drain_w_hold", 64'(slv_rsp.w_ready), 64'd0);
        tick();
        chk("wr_absorb_ready0", 64'(slv_rsp.w_ready), 64'd1);
        chk("wr_absorb_nofwd0", 64'(mst_req.w_valid), 64'd0);
        tick();
        slv_req.w.data = 64'hB1;
        slv_req.w.last = 1'b1;
        #1;
        chk("wr_absorb_ready1", 64'(slv_rsp.w_ready), 64'd1);
        chk("wr_absorb_nofwd1", 64'(mst_req.w_valid), 64'd0);
        slv_req.b_ready = 1'b0;
        tick();
        slv_req.w_valid = 1'b0;
        #1;
        chk("wr_b_valid", 64'(slv_rsp.b_valid), 64'd1);
        chk("wr_b_id",    64'(slv_rsp.b.id),    64'd2);
        chk("wr_b_resp",  64'(slv_rsp.b.resp),  64'(c_RESP_DECERR));
        chk("wr_err_cnt", 64'(err_cnt),         64'(c_ERR_STEP));
        tick();
        chk("wr_b_hold_valid", 64'(slv_rsp.b_valid), 64'd1);
        chk("wr_b_hold_id",    64'(slv_rsp.b.id),    64'd2);
        slv_req.b_ready = 1'b1;
        tick();
        chk("wr_b_done", 64'(slv_rsp.b_valid), 64'd0);

        // W presented while AW is delayed 5 cycles
        slv_req.w.data  = 64'hC0;
        slv_req.w.last  = 1'b1;
        slv_req.w_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wba_w_hold", 64'(slv_rsp.w_ready), 64'd0);
            chk("wba_no_fwd", 64'(mst_req.w_valid), 64'd0);
            tick();
        end
        slv_req.aw.id    = 4'd3;
        slv_req.aw.addr  = c_ADDR_HIT;
        slv_req.aw.len   = 8'd0;
        slv_req.aw_valid = 1'b1;
        #1;
        chk("wba_aw_fwd",  64'(mst_req.aw_valid), 64'd1);
        chk("wba_w_still", 64'(slv_rsp.w_ready),  64'd0);
        tick();
        slv_req.aw_valid = 1'b0;
        #1;
        chk("wba_w_ready", 64'(slv_rsp.w_ready), 64'd1);
        chk("wba_w_fwd",   64'(mst_req.w_valid), 64'd1);
        tick();
        slv_req.w_valid = 1'b0;
        mst_rsp.b_valid = 1'b1;
        mst_rsp.b.id    = 4'd3;
        #1;
        chk("wba_b_id", 64'(slv_rsp.b.id), 64'd3);
        tick();
        mst_rsp.b_valid = 1'b0;

        // Read reject behind an outstanding matching read
        slv_req.ar.id    = 4'd1;
        slv_req.ar.addr  = c_ADDR_HIT;
        slv_req.ar.len   = 8'd0;
        slv_req.ar_valid = 1'b1;
        #1;
        chk("rd_ar_fwd",   64'(mst_req.ar_valid), 64'd1);
        chk("rd_ar_ready", 64'(slv_rsp.ar_ready), 64'd1);
        tick();
        slv_req.ar.addr = c_ADDR_MISS;
        slv_req.ar.len  = 8'd2;
        #1;
        chk("rd_rej_ready",  64'(slv_rsp.ar_ready), 64'd1);
        chk("rd_rej_no_fwd", 64'(mst_req.ar_valid), 64'd0);
        tick();
        slv_req.ar_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("rd_drain_quiet", 64'(slv_rsp.r_valid), 64'd0);
            tick();
        end
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.id    = 4'd1;
        mst_rsp.r.data  = 64'hDEAD;
        mst_rsp.r.resp  = c_RESP_OKAY;
        mst_rsp.r.last  = 1'b1;
        #1;
        chk("rd_down_valid", 64'(slv_rsp.r_valid), 64'd1);
        chk("rd_down_data",  slv_rsp.r.data,       64'hDEAD);
        chk("rd_down_ready", 64'(mst_req.r_ready), 64'd1);
        tick();
        mst_rsp.r_valid = 1'b0;
        #1;
        chk("rd_gap_quiet", 64'(slv_rsp.r_valid), 64'd0);
        tick();
        slv_req.r_ready = 1'b0;
        #1;
        chk("rd_b0_valid", 64'(slv_rsp.r_valid), 64'd1);
        chk("rd_b0_id",    64'(slv_rsp.r.id),    64'd1);
        chk("rd_b0_resp",  64'(slv_rsp.r.resp),  64'(c_RESP_DECERR));
        chk("rd_b0_data",  slv_rsp.r.data,       64'd0);
        chk("rd_b0_last",  64'(slv_rsp.r.last),  64'd0);
        tick();
        chk("rd_b0_hold",      64'(slv_rsp.r_valid), 64'd1);
        chk("rd_b0_hold_last", 64'(slv_rsp.r.last),  64'd0);
        slv_req.r_ready = 1'b1;
        tick();
        chk("rd_b1_valid", 64'(slv_rsp.r_valid), 64'd1);
        chk("rd_b1_last",  64'(slv_rsp.r.last),  64'd0);
        tick();
        chk("rd_b2_valid", 64'(slv_rsp.r_valid), 64'd1);
        chk("rd_b2_last",  64'(slv_rsp.r.last),  64'd1);
        tick();
        chk("rd_done",    64'(slv_rsp.r_valid), 64'd0);
        chk("rd_err_cnt", 64'(err_cnt),         64'(2 * c_ERR_STEP));

        // Outstanding limit: 16 accepted, 17th waits for an rlast
        slv_req.ar.id    = 4'd4;
        slv_req.ar.addr  = c_ADDR_HIT;
        slv_req.ar.len   = 8'd0;
        slv_req.ar_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("lim_ready", 64'(slv_rsp.ar_ready), 64'd1);
            tick();
        end
        chk("lim_stall_ready", 64'(slv_rsp.ar_ready), 64'd0);
        chk("lim_stall_valid", 64'(mst_req.ar_valid), 64'd0);
        tick();
        mst_rsp.r_valid = 1'b1;
        mst_rsp.r.id    = 4'd4;
        mst_rsp.r.last  = 1'b1;
        #1;
        chk("lim_same_cycle", 64'(slv_rsp.ar_ready), 64'd0);
        tick();
        mst_rsp.r_valid = 1'b0;
        #1;
        chk("lim_unblock_ready", 64'(slv_rsp.ar_ready), 64'd1);
        chk("lim_unblock_valid", 64'(mst_req.ar_valid), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
        mst_rsp.r_valid  = 1'b1;
        repeat (16) tick();
        mst_rsp.r_valid = 1'b0;

        // Reset during an error burst
        slv_req.ar.id    = 4'd5;
        slv_req.ar.addr  = c_ADDR_MISS;
        slv_req.ar.len   = 8'd3;
        slv_req.ar_valid = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        tick();
        chk("rb_b0_valid", 64'(slv_rsp.r_valid), 64'd1);
        tick();
        chk("rb_b1_valid", 64'(slv_rsp.r_valid), 64'd1);
        chk("rb_b1_last",  64'(slv_rsp.r.last),  64'd0);
        rst_n = 1'b0;
        #1;
        chk("rb_rst_r_valid",  64'(slv_rsp.r_valid),  64'd0);
        chk("rb_rst_b_valid",  64'(slv_rsp.b_valid),  64'd0);
        chk("rb_rst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
        chk("rb_rst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
        chk("rb_rst_w_valid",  64'(mst_req.w_valid),  64'd0);
        chk("rb_rst_aw_ready", 64'(slv_rsp.aw_ready), 64'd0);
        chk("rb_rst_ar_ready", 64'(slv_rsp.ar_ready), 64'd0);
        chk("rb_rst_err_cnt",  64'(err_cnt),          64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        slv_req.ar.id    = 4'd6;
        slv_req.ar.addr  = c_ADDR_HIT;
        slv_req.ar.len   = 8'd0;
        slv_req.ar_valid = 1'b1;
        #1;
        chk("post_rst_ar_fwd",   64'(mst_req.ar_valid), 64'd1);
        chk("post_rst_ar_ready", 64'(slv_rsp.ar_ready), 64'd1);
        chk("post_rst_r_quiet",  64'(slv_rsp.r_valid),  64'd0);
        tick();
        slv_req.ar_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
